// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, default
// widths and the starvation-guard limit.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCK_L = 1'b1
    } arb_state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_MAX_LOCK = 16;

    // Counter must hold 0..max_lock inclusive; never narrower than one bit.
    function automatic int lock_cnt_width(input int max_lock);
        int w;
        w = $clog2(max_lock + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port (core / loader) arbiter in front of a single-ported data memory,
// with a loader burst lock bounded by a core starvation counter.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,

    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    input  logic              l_lock,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,

    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int               CNT_W   = lock_cnt_width(MAX_LOCK);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    arb_state_t       state_reg, state_next;
    logic             prio_l_reg, prio_l_next;   // 1: loader wins a tie
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             own_l_reg, own_l_next;
    logic             pend_reg, pend_next;

    logic             gnt_c, gnt_l;
    logic             locked;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ARB:     if (gnt_l && l_lock) state_next = LOCK_L;
            LOCK_L:  if (!l_lock)         state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: grant decision
    // ------------------------------------------------------------------
    // Lock only takes effect while l_lock is still held; the release cycle
    // is arbitrated exactly as in ARB.
    assign locked = (state_reg == LOCK_L) && l_lock;

    always_comb begin
        gnt_c = 1'b0;
        gnt_l = 1'b0;
        if (!rst) begin
            if (locked) begin
                if (c_req && (cnt_reg == CNT_MAX || !l_req)) begin
                    gnt_c = 1'b1;
                end else if (l_req) begin
                    gnt_l = 1'b1;
                end
            end else if (c_req && l_req) begin
                gnt_l = prio_l_reg;
                gnt_c = !prio_l_reg;
            end else begin
                gnt_c = c_req;
                gnt_l = l_req;
            end
        end
    end

    assign c_gnt = gnt_c;
    assign l_gnt = gnt_l;

    // ------------------------------------------------------------------
    // Round-robin pointer and starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        prio_l_next = prio_l_reg;
        if (gnt_c) begin
            prio_l_next = 1'b1;
        end else if (gnt_l) begin
            prio_l_next = 1'b0;
        end
    end

    // Counts locked loader grants the core has been waiting through,
    // including the grant that opens the lock.
    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != LOCK_L || !c_req || gnt_c) begin
            cnt_next = '0;
        end else if (gnt_l && cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_l_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            prio_l_reg <= prio_l_next;
            cnt_reg    <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Memory port
    // ------------------------------------------------------------------
    always_comb begin
        m_en    = gnt_c || gnt_l;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (gnt_c) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (gnt_l) begin
            m_we    = l_we;
            m_addr  = l_addr;
            m_wdata = l_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read response tracking
    // ------------------------------------------------------------------
    assign pend_next  = m_en && !m_we;
    assign own_l_next = gnt_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg  <= 1'b0;
            own_l_reg <= 1'b0;
        end else begin
            pend_reg  <= pend_next;
            own_l_reg <= own_l_next;
        end
    end

    // Gated by rst so a response already in flight when reset hits is dropped.
    assign c_rvalid = !rst && pend_reg && !own_l_reg;
    assign l_rvalid = !rst && pend_reg &&  own_l_reg;
    assign c_rdata  = c_rvalid ? m_rdata : '0;
    assign l_rdata  = l_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed core/loader traffic against a
// behavioural memory, with grant order and read data checked by a monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lock;
    } txn_t;

    txn_t        c_txq[$];
    txn_t        l_txq[$];
    logic        exp_gnt_q[$];   // 0 = core, 1 = loader
    logic [31:0] exp_c_q[$];
    logic [31:0] exp_l_q[$];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .MAX_LOCK (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .l_req    (l_req),
        .l_we     (l_we),
        .l_addr   (l_addr),
        .l_wdata  (l_wdata),
        .l_lock   (l_lock),
        .l_gnt    (l_gnt),
        .l_rvalid (l_rvalid),
        .l_rdata  (l_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    // Behavioural memory: untouched words read as a known fill pattern.
    logic [31:0] mem [256];
    bit          written [256];

    function automatic logic [31:0] fill_word(input int idx);
        return (idx == 4) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(idx);
    endfunction

    function automatic logic [31:0] mem_word(input int idx);
        return written[idx] ? mem[idx] : fill_word(idx);
    endfunction

    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                mem[m_addr[9:2]]     <= m_wdata;
                written[m_addr[9:2]] <= 1'b1;
            end else begin
                m_rdata <= mem_word(int'(m_addr[9:2]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic exp_owner;

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (c_gnt || l_gnt || c_rvalid || l_rvalid || m_en || m_we ||
                c_rdata != 32'h0 || l_rdata != 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: gnt c/l=%b/%b rvalid c/l=%b/%b m_en=%b m_we=%b c_rdata=%h l_rdata=%h, required all 0",
                         c_gnt, l_gnt, c_rvalid, l_rvalid, m_en, m_we, c_rdata, l_rdata);
            end
        end else begin
            if (c_gnt || l_gnt) begin
                checks++;
                if (c_gnt && l_gnt) begin
                    errors++;
                    $display("FAIL grant_double: c_gnt=1 l_gnt=1, required at most one");
                end else if ((c_gnt && !c_req) || (l_gnt && !l_req)) begin
                    errors++;
                    $display("FAIL grant_no_req: gnt c/l=%b/%b req c/l=%b/%b", c_gnt, l_gnt, c_req, l_req);
                end else if (exp_gnt_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: got %s, required none", l_gnt ? "L" : "C");
                end else begin
                    exp_owner = exp_gnt_q.pop_front();
                    if (l_gnt != exp_owner) begin
                        errors++;
                        $display("FAIL grant_order: got %s, required %s", l_gnt ? "L" : "C", exp_owner ? "L" : "C");
                    end
                end
                checks++;
                if (!m_en || m_we  != (c_gnt ? c_we    : l_we) ||
                             m_addr  != (c_gnt ? c_addr  : l_addr) ||
                             (m_we && m_wdata != (c_gnt ? c_wdata : l_wdata))) begin
                    errors++;
                    $display("FAIL mem_port: m_en=%b m_we=%b m_addr=%h m_wdata=%h, required fields of port %s",
                             m_en, m_we, m_addr, m_wdata, c_gnt ? "C" : "L");
                end
            end else begin
                checks++;
                if (m_en || m_we) begin
                    errors++;
                    $display("FAIL mem_idle: m_en=%b m_we=%b, required 0/0", m_en, m_we);
                end
            end

            if (c_rvalid) begin
                checks++;
                if (l_rvalid || l_rdata != 32'h0) begin
                    errors++;
                    $display("FAIL loader_quiet: l_rvalid=%b l_rdata=%h, required 0/0", l_rvalid, l_rdata);
                end else if (exp_c_q.size() == 0) begin
                    errors++;
                    $display("FAIL core_rvalid_unexpected: c_rdata=%h, required no response", c_rdata);
                end else if (c_rdata != exp_c_q[0]) begin
                    errors++;
                    $display("FAIL core_rdata: got %h, required %h", c_rdata, exp_c_q[0]);
                end
                if (exp_c_q.size() != 0) void'(exp_c_q.pop_front());
            end else if (l_rvalid) begin
                checks++;
                if (c_rdata != 32'h0) begin
                    errors++;
                    $display("FAIL core_quiet: c_rdata=%h, required 0", c_rdata);
                end else if (exp_l_q.size() == 0) begin
                    errors++;
                    $display("FAIL loader_rvalid_unexpected: l_rdata=%h, required no response", l_rdata);
                end else if (l_rdata != exp_l_q[0]) begin
                    errors++;
                    $display("FAIL loader_rdata: got %h, required %h", l_rdata, exp_l_q[0]);
                end
                if (exp_l_q.size() != 0) void'(exp_l_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic void c_push(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        c_txq.push_back('{we: we, addr: addr, wdata: wdata, lock: 1'b0});
    endfunction

    function automatic void l_push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic lock);
        l_txq.push_back('{we: we, addr: addr, wdata: wdata, lock: lock});
    endfunction

    function automatic void exp_pattern(input string s);
        for (int i = 0; i < s.len(); i++) exp_gnt_q.push_back(s[i] == "L");
    endfunction

    // Each driver holds a request until granted, then presents the next one.
    task automatic run_core(output int first_wait);
        txn_t t;
        int   n;
        bit   first;
        first      = 1'b1;
        first_wait = 0;
        while (c_txq.size() > 0) begin
            t       = c_txq.pop_front();
            c_req   = 1'b1;
            c_we    = t.we;
            c_addr  = t.addr;
            c_wdata = t.wdata;
            n = 0;
            @(negedge clk);
            while (!c_gnt && n < 100) begin
                n++;
                @(negedge clk);
            end
            if (first) first_wait = n;
            first = 1'b0;
            if (!c_gnt) begin
                checks++;
                errors++;
                $display("FAIL core_grant_timeout: no grant after %0d cycles, required grant", n);
                c_txq.delete();
            end
            @(posedge clk);
            #1;
        end
        c_req   = 1'b0;
        c_we    = 1'b0;
        c_addr  = 32'h0;
        c_wdata = 32'h0;
    endtask

    task automatic run_loader();
        txn_t t;
        int   n;
        while (l_txq.size() > 0) begin
            t       = l_txq.pop_front();
            l_req   = 1'b1;
            l_we    = t.we;
            l_addr  = t.addr;
            l_wdata = t.wdata;
            l_lock  = t.lock;
            n = 0;
            @(negedge clk);
            while (!l_gnt && n < 100) begin
                n++;
                @(negedge clk);
            end
            if (!l_gnt) begin
                checks++;
                errors++;
                $display("FAIL loader_grant_timeout: no grant after %0d cycles, required grant", n);
                l_txq.delete();
            end
            @(posedge clk);
            #1;
        end
        l_req   = 1'b0;
        l_we    = 1'b0;
        l_lock  = 1'b0;
        l_addr  = 32'h0;
        l_wdata = 32'h0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_gnt_q.size() != 0 || exp_c_q.size() != 0 || exp_l_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: pending grants/core/loader = %0d/%0d/%0d, required 0/0/0",
                     name, exp_gnt_q.size(), exp_c_q.size(), exp_l_q.size());
        end
        exp_gnt_q.delete();
        exp_c_q.delete();
        exp_l_q.delete();
        $display("scenario %s done", name);
    endtask

    task automatic run_both(input string name);
        int wc;
        @(posedge clk);
        #1;
        fork
            run_core(wc);
            run_loader();
        join
        drain(name);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int          wc;
        logic [31:0] want;
        rst = 1'b1;
        c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
        l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0; l_lock = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;

        // Both ports contend from reset: alternation starting with the core.
        c_push(1'b0, 32'h10, 32'h0);
        c_push(1'b0, 32'h14, 32'h0);
        l_push(1'b0, 32'h18, 32'h0, 1'b0);
        l_push(1'b0, 32'h1C, 32'h0, 1'b0);
        exp_pattern("CLCL");
        exp_c_q.push_back(32'hDEAD_BEEF);
        exp_c_q.push_back(32'h1000_0005);
        exp_l_q.push_back(32'h1000_0006);
        exp_l_q.push_back(32'h1000_0007);
        run_both("rr_alternate");

        // Lone core read.
        c_push(1'b0, 32'h10, 32'h0);
        exp_pattern("C");
        exp_c_q.push_back(32'hDEAD_BEEF);
        run_both("core_read");

        // Core write followed by read-back; the write itself yields no response.
        c_push(1'b1, 32'h20, 32'h55);
        c_push(1'b0, 32'h20, 32'h0);
        exp_pattern("CC");
        exp_c_q.push_back(32'h0000_0055);
        run_both("write_readback");

        // Locked loader burst vs. a waiting core; MAX_LOCK=4 lets the core in
        // after every fourth locked grant.
        for (int i = 0; i < 16; i++) l_push(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i * 4), 1'b1);
        for (int i = 0; i < 4; i++) begin
            c_push(1'b0, 32'h40 + 32'(i * 4), 32'h0);
            exp_c_q.push_back(32'h1000_0010 + 32'(i));
        end
        exp_pattern("LLLLCLLLLCLLLLCLLLLC");
        run_both("lock_burst");
        for (int i = 0; i < 16; i++) begin
            want = 32'hA000_0000 + 32'(i * 4);
            checks++;
            if (mem_word(i) != want) begin
                errors++;
                $display("FAIL burst_word[%0d]: got %h, required %h", i, mem_word(i), want);
            end
        end

        // Lock released mid-burst while the core waits: core wins the release cycle.
        l_push(1'b1, 32'h100, 32'h1111_0000, 1'b1);
        l_push(1'b1, 32'h104, 32'h2222_0000, 1'b1);
        l_push(1'b0, 32'h48,  32'h0,         1'b0);
        l_push(1'b0, 32'h4C,  32'h0,         1'b0);
        c_push(1'b1, 32'h200, 32'h3333_0000);
        exp_pattern("LLCLL");
        exp_l_q.push_back(32'h1000_0012);
        exp_l_q.push_back(32'h1000_0013);
        run_both("lock_release");

        // Reset lands the cycle after a granted loader read: response is dropped.
        l_push(1'b0, 32'h40, 32'h0, 1'b0);
        exp_pattern("L");
        @(posedge clk);
        #1;
        run_loader();
        rst = 1'b1;
        c_req = 1'b1; c_addr = 32'h44;
        l_req = 1'b1; l_addr = 32'h44;
        repeat (3) @(posedge clk);
        #1;
        c_req = 1'b0;
        l_req = 1'b0;
        rst   = 1'b0;
        c_push(1'b0, 32'h44, 32'h0);
        exp_pattern("C");
        exp_c_q.push_back(32'h1000_0011);
        run_core(wc);
        checks++;
        if (wc != 0) begin
            errors++;
            $display("FAIL first_grant_after_reset: waited %0d cycles, required 0", wc);
        end
        drain("reset_drop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
